// File: rtl/inst_fetch_stage_pkg.sv
// rtl/inst_fetch_stage_pkg.sv - widths, FSM encoding and instruction-queue entry layout for the fetch stage
package inst_fetch_stage_pkg;

  localparam int kAddrWidth = 32;
  localparam int kDataWidth = 32;
  localparam logic [kAddrWidth-1:0] kResetPc   = 32'hbfc00000;
  localparam logic [kAddrWidth-1:0] kInstBytes = kAddrWidth'(4);

  // Entry layout {addr_err, pc, inst}; decode slices the queue word with the same offsets.
  localparam int kEntryWidth   = 1 + kAddrWidth + kDataWidth;
  localparam int kEntryInstLsb = 0;
  localparam int kEntryPcLsb   = kDataWidth;
  localparam int kEntryErrBit  = kAddrWidth + kDataWidth;

  typedef enum logic [1:0] {
    kFetchIdle    = 2'd0,
    kFetchReq     = 2'd1,
    kFetchWait    = 2'd2,
    kFetchDiscard = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic                  addr_err;
    logic [kAddrWidth-1:0] pc;
    logic [kDataWidth-1:0] inst;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic                  addr_err,
                                              input logic [kAddrWidth-1:0] pc,
                                              input logic [kDataWidth-1:0] inst);
    fetch_entry_t e;
    e.addr_err = addr_err;
    e.pc       = pc;
    e.inst     = inst;
    return e;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// rtl/inst_fetch_stage_if.sv - instruction bus and instruction-queue write port of the fetch stage
interface inst_fetch_stage_if;
  import inst_fetch_stage_pkg::*;

  logic                   imem_req;
  logic [kAddrWidth-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [kDataWidth-1:0]  imem_rdata;
  logic                   fifo_full;
  logic                   fifo_write_en;
  logic [kEntryWidth-1:0] fifo_write_data;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, fifo_write_en, fifo_write_data,
    input  imem_gnt, imem_rvalid, imem_rdata, fifo_full
  );

  // Memory / instruction queue side.
  modport slave (
    input  imem_req, imem_addr, fifo_write_en, fifo_write_data,
    output imem_gnt, imem_rvalid, imem_rdata, fifo_full
  );

endinterface

// File: rtl/inst_fetch_stage_out_buffer.sv
// rtl/inst_fetch_stage_out_buffer.sv - one-entry hold register that pushes into the instruction queue when it has room
module inst_fetch_stage_out_buffer
  import inst_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  fetch_entry_t           load_entry_i,
  input  logic                   fifo_full_i,
  output logic                   hold_valid_o,
  output logic                   write_en_o,
  output logic [kEntryWidth-1:0] write_data_o
);

  fetch_entry_t hold_q;
  logic         hold_valid_q;

  assign hold_valid_o = hold_valid_q;
  assign write_en_o   = hold_valid_q && !fifo_full_i;

  assign write_data_o[kEntryErrBit]                = hold_q.addr_err;
  assign write_data_o[kEntryPcLsb +: kAddrWidth]   = hold_q.pc;
  assign write_data_o[kEntryInstLsb +: kDataWidth] = hold_q.inst;

  // A load beats a same-cycle push so a new entry is never lost; a redirect empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
    end else if (load_i) begin
      hold_valid_q <= 1'b1;
      hold_q       <= load_entry_i;
    end else if (write_en_o) begin
      hold_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - PC generation, single-outstanding instruction fetch and queue push; FETCH_ADDR_CHECK_EN enables misaligned-PC halt
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [kAddrWidth-1:0] redirect_pc,
  inst_fetch_stage_if.master    bus
);

  fetch_state_e           state_q;
  logic [kAddrWidth-1:0]  pc_q;
  logic [kAddrWidth-1:0]  pending_pc_q;
  logic                   hold_valid;
  logic                   issue_ok;
  logic                   misaligned;
  logic                   halted;
  logic                   load_d;
  fetch_entry_t           load_entry_d;
  logic                   fifo_we;
  logic [kEntryWidth-1:0] fifo_wdata;

`ifdef FETCH_ADDR_CHECK_EN
  logic halted_q;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign halted     = halted_q;
`else
  assign misaligned = 1'b0;
  assign halted     = 1'b0;
`endif

  // Leave IDLE only if the hold slot is empty or draining this cycle.
  assign issue_ok = !stall && !halted && (!hold_valid || !bus.fifo_full);

  assign bus.imem_req        = (state_q == kFetchReq);
  assign bus.imem_addr       = pc_q;
  assign bus.fifo_write_en   = fifo_we;
  assign bus.fifo_write_data = fifo_wdata;

  // Choose what enters the hold slot: a live response, or an address-error marker.
  always_comb begin
    load_d       = 1'b0;
    load_entry_d = make_entry(1'b0, pending_pc_q, bus.imem_rdata);
    if (!redirect_en) begin
      if (state_q == kFetchWait && bus.imem_rvalid) begin
        load_d = 1'b1;
      end else if (state_q == kFetchIdle && issue_ok && misaligned) begin
        load_d       = 1'b1;
        load_entry_d = make_entry(1'b1, pc_q, '0);
      end
    end
  end

  // Fetch FSM: redirect wins over everything and routes in-flight responses to DISCARD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= kFetchIdle;
      pc_q         <= kResetPc;
      pending_pc_q <= kResetPc;
`ifdef FETCH_ADDR_CHECK_EN
      halted_q     <= 1'b0;
`endif
    end else if (redirect_en) begin
      pc_q <= redirect_pc;
`ifdef FETCH_ADDR_CHECK_EN
      halted_q <= 1'b0;
`endif
      case (state_q)
        kFetchReq:     state_q <= bus.imem_gnt ? kFetchDiscard : kFetchReq;
        kFetchWait,
        kFetchDiscard: state_q <= bus.imem_rvalid ? kFetchIdle : kFetchDiscard;
        default:       state_q <= kFetchIdle;
      endcase
    end else begin
      case (state_q)
        kFetchIdle: begin
          if (issue_ok && !misaligned) state_q <= kFetchReq;
`ifdef FETCH_ADDR_CHECK_EN
          if (issue_ok && misaligned) halted_q <= 1'b1;
`endif
        end
        kFetchReq: begin
          if (bus.imem_gnt) begin
            pending_pc_q <= pc_q;
            pc_q         <= pc_q + kInstBytes;
            state_q      <= kFetchWait;
          end
        end
        kFetchWait: begin
          if (bus.imem_rvalid) state_q <= kFetchIdle;
        end
        default: begin
          if (bus.imem_rvalid) state_q <= kFetchIdle;
        end
      endcase
    end
  end

  inst_fetch_stage_out_buffer u_out_buffer (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_en),
    .load_i       (load_d),
    .load_entry_i (load_entry_d),
    .fifo_full_i  (bus.fifo_full),
    .hold_valid_o (hold_valid),
    .write_en_o   (fifo_we),
    .write_data_o (fifo_wdata)
  );

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - directed bench with PC model and push scoreboard for inst_fetch_stage
module tb_inst_fetch_stage;
  import inst_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  inst_fetch_stage_if bus();

  inst_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [64:0] exp_q[$];
  logic [31:0] model_pc;

  function automatic logic [64:0] ent(input logic err, input logic [31:0] pc, input logic [31:0] inst);
    return {err, pc, inst};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk65(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Fetch address the core should present: reset vector, redirect target, or +4 per accepted request.
  always @(posedge clk) begin
    if (rst) model_pc = 32'hbfc00000;
    else if (redirect_en) model_pc = redirect_pc;
    else if (bus.imem_req && bus.imem_gnt) model_pc = model_pc + 32'd4;
  end

  // Every cycle: request address follows the model, pushes match the expected entry order.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req) chk32("req_addr", bus.imem_addr, model_pc);
      if (bus.fifo_write_en) begin
        chk1("push_while_full", bus.fifo_full, 1'b0);
        chk1("push_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk65("push_data", bus.fifo_write_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_req(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (bus.imem_req) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk1(name, seen, 1'b1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.fifo_full = 1'b0;
    repeat (2) cyc();
    at_neg();
    chk1("rst_req", bus.imem_req, 1'b0);
    chk32("rst_addr", bus.imem_addr, 32'hbfc00000);
    chk1("rst_we", bus.fifo_write_en, 1'b0);
    chk65("rst_wdata", bus.fifo_write_data, 65'd0);
    cyc(); rst = 1'b0;

    // 1: zero-wait fetch from the reset vector
    wait_req("t1_req_seen");
    chk32("t1_addr", bus.imem_addr, 32'hbfc00000);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000013;
    exp_q.push_back(ent(1'b0, 32'hbfc00000, 32'h00000013));
    at_neg(); chk1("t1_req_wait", bus.imem_req, 1'b0); chk1("t1_we_early", bus.fifo_write_en, 1'b0);
    cyc(); bus.imem_rvalid = 1'b0;
    at_neg(); chk1("t1_we", bus.fifo_write_en, 1'b1);
    chk65("t1_data", bus.fifo_write_data, ent(1'b0, 32'hbfc00000, 32'h00000013));
    cyc();
    at_neg(); chk1("t1_next_req", bus.imem_req, 1'b1); chk32("t1_next_addr", bus.imem_addr, 32'hbfc00004);

    // 2: queue full for 5 cycles holds the entry and blocks new requests
    cyc(); bus.imem_gnt = 1'b1; bus.fifo_full = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00100113;
    exp_q.push_back(ent(1'b0, 32'hbfc00004, 32'h00100113));
    cyc(); bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg(); chk1("t2_we_full", bus.fifo_write_en, 1'b0); chk1("t2_req_full", bus.imem_req, 1'b0);
      cyc();
    end
    bus.fifo_full = 1'b0;
    at_neg(); chk1("t2_we", bus.fifo_write_en, 1'b1);
    chk65("t2_data", bus.fifo_write_data, ent(1'b0, 32'hbfc00004, 32'h00100113));
    cyc();
    at_neg(); chk1("t2_req", bus.imem_req, 1'b1); chk32("t2_addr", bus.imem_addr, 32'hbfc00008);

    // 3: redirect while waiting; the late response is dropped
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h80000180;
    cyc(); redirect_en = 1'b0;
    at_neg(); chk1("t3_req_discard", bus.imem_req, 1'b0);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hdeadbeef;
    cyc(); bus.imem_rvalid = 1'b0;
    at_neg(); chk1("t3_we_drop", bus.fifo_write_en, 1'b0);
    cyc();
    at_neg(); chk1("t3_req", bus.imem_req, 1'b1); chk32("t3_addr", bus.imem_addr, 32'h80000180);

    // 4a: redirect in the same cycle as gnt
    cyc(); bus.imem_gnt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h80000200;
    cyc(); bus.imem_gnt = 1'b0; redirect_en = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hbad00001;
    cyc(); bus.imem_rvalid = 1'b0;
    at_neg(); chk1("t4a_we_drop", bus.fifo_write_en, 1'b0);
    cyc();
    at_neg(); chk1("t4a_req", bus.imem_req, 1'b1); chk32("t4a_addr", bus.imem_addr, 32'h80000200);
    // 4b: redirect in the same cycle as rvalid
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hbad00002;
    redirect_en = 1'b1; redirect_pc = 32'h80000300;
    cyc(); bus.imem_rvalid = 1'b0; redirect_en = 1'b0;
    at_neg(); chk1("t4b_we_drop", bus.fifo_write_en, 1'b0);
    cyc();
    at_neg(); chk1("t4b_req", bus.imem_req, 1'b1); chk32("t4b_addr", bus.imem_addr, 32'h80000300);
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00200193;
    exp_q.push_back(ent(1'b0, 32'h80000300, 32'h00200193));
    cyc(); bus.imem_rvalid = 1'b0;
    at_neg(); chk65("t4_data", bus.fifo_write_data, ent(1'b0, 32'h80000300, 32'h00200193));
    cyc();
    at_neg(); chk32("t4_next_addr", bus.imem_addr, 32'h80000304);

    // 5: redirect during REQ without gnt keeps req asserted and retargets the address
    cyc(); redirect_en = 1'b1; redirect_pc = 32'h80000400;
    at_neg(); chk32("t5_addr_old", bus.imem_addr, 32'h80000304);
    cyc(); redirect_en = 1'b0;
    at_neg(); chk1("t5_req", bus.imem_req, 1'b1); chk32("t5_addr_new", bus.imem_addr, 32'h80000400);
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00300213;
    exp_q.push_back(ent(1'b0, 32'h80000400, 32'h00300213));
    cyc(); bus.imem_rvalid = 1'b0; stall = 1'b1;
    at_neg(); chk1("t5_we", bus.fifo_write_en, 1'b1);
    cyc(); stall = 1'b0;
    at_neg(); chk1("t5_req_stalled", bus.imem_req, 1'b0);
    cyc();
    at_neg(); chk1("t5_req_resume", bus.imem_req, 1'b1); chk32("t5_addr_resume", bus.imem_addr, 32'h80000404);

    // 6: redirect to a misaligned PC
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00a00093;
    exp_q.push_back(ent(1'b0, 32'h80000404, 32'h00a00093));
    cyc(); bus.imem_rvalid = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h80000002;
    at_neg(); chk1("t6_we_prev", bus.fifo_write_en, 1'b1);
    cyc(); redirect_en = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
    exp_q.push_back(ent(1'b1, 32'h80000002, 32'h0));
    at_neg(); chk1("t6_req0", bus.imem_req, 1'b0);
    cyc();
    at_neg(); chk1("t6_we_err", bus.fifo_write_en, 1'b1); chk1("t6_req_err", bus.imem_req, 1'b0);
    chk65("t6_err_data", bus.fifo_write_data, ent(1'b1, 32'h80000002, 32'h0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      at_neg(); chk1("t6_halt_req", bus.imem_req, 1'b0); chk1("t6_halt_we", bus.fifo_write_en, 1'b0);
    end
    cyc(); redirect_en = 1'b1; redirect_pc = 32'h80000500;
    cyc(); redirect_en = 1'b0;
    at_neg(); chk1("t6_req_idle", bus.imem_req, 1'b0);
    cyc();
    at_neg(); chk1("t6_req_restart", bus.imem_req, 1'b1); chk32("t6_addr_restart", bus.imem_addr, 32'h80000500);
`else
    at_neg(); chk1("t6_req0", bus.imem_req, 1'b0);
    cyc();
    at_neg(); chk1("t6_req", bus.imem_req, 1'b1); chk32("t6_addr_raw", bus.imem_addr, 32'h80000002);
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00b00113;
    exp_q.push_back(ent(1'b0, 32'h80000002, 32'h00b00113));
    cyc(); bus.imem_rvalid = 1'b0;
    at_neg(); chk65("t6_data", bus.fifo_write_data, ent(1'b0, 32'h80000002, 32'h00b00113));
    cyc();
    at_neg(); chk32("t6_next_addr", bus.imem_addr, 32'h80000006);
`endif

    // 7: reset while a response is due drops it and restarts at the reset vector
    cyc(); bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hbad0bad0; rst = 1'b1;
    cyc(); rst = 1'b0; bus.imem_rvalid = 1'b0;
    at_neg(); chk1("t7_we", bus.fifo_write_en, 1'b0); chk1("t7_req", bus.imem_req, 1'b0);
    chk32("t7_addr", bus.imem_addr, 32'hbfc00000);
    cyc();
    at_neg(); chk1("t7_req_again", bus.imem_req, 1'b1); chk32("t7_addr_again", bus.imem_addr, 32'hbfc00000);

    chk32("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
